// File: rtl/shift_pkg.sv
// Shared types and helpers for the two-stage shift execution unit.
// Rotate support is selected by the SHIFT_ROTATE_EN macro in shift_exec_pipe.sv.
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } shift_op_e;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_exec_pipe_if.sv
// Upstream op and downstream result handshakes of shift_exec_pipe.
// slave is the unit's view, master is the driver/consumer view.
interface shift_exec_pipe_if
  import shift_pkg::*;
#(
  parameter int TAG_W = 5
) ();

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [XLEN-1:0]    in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result;
  logic [TAG_W-1:0]   out_tag;
  logic               out_illegal;

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );

  modport master (
    output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );

endinterface

// File: rtl/barrel_shifter_left.sv
// Logarithmic left barrel shifter; zero fill, one stage per amount bit.
module barrel_shifter_left #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shifted_s;

  // Stage k shifts by 2**k when amount bit k is set.
  always_comb begin
    shifted_s = data_i;
    for (int i = 0; i < AMT_W; i++) begin
      shifted_s = amt_i[i] ? (shifted_s << (32'd1 << i)) : shifted_s;
    end
  end

  assign data_o = shifted_s;

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage pipelined shift unit; every direction is built from left shifts and bit reversal.
// Define SHIFT_ROTATE_EN to make ROL/ROR legal; otherwise op codes 3 and 4 report illegal.
module shift_exec_pipe #(
  parameter int XLEN  = shift_pkg::XLEN,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  shift_exec_pipe_if.slave io
);
  import shift_pkg::*;

  if (XLEN != 32) begin : g_xlen_check
    $error("shift_exec_pipe: only XLEN=32 is supported");
  end

  logic               s1_valid_q, s1_valid_d, s1_load_s;
  logic [2:0]         s1_op_q;
  logic [XLEN-1:0]    s1_data_q;
  logic [SHAMT_W-1:0] s1_shamt_q;
  logic [TAG_W-1:0]   s1_tag_q;
  logic               s2_valid_q, s2_valid_d, s2_load_s;
  logic [XLEN-1:0]    s2_result_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic               s2_illegal_q;
  logic               s2_adv_s, in_ready_s;

  logic [XLEN-1:0]    x_rev_s, main_in_s, aux_in_s, main_out_s, aux_out_s, res_s;
  logic [SHAMT_W-1:0] main_amt_s, aux_amt_s;
  logic               illegal_s;
`ifdef SHIFT_ROTATE_EN
  logic [SHAMT_W-1:0] rot_amt_s;
`endif

  assign s2_adv_s   = !s2_valid_q || io.out_ready;
  assign in_ready_s = !s1_valid_q || s2_adv_s;

  // Stage valids: flush wins over accept and advance; data registers load only on a real move.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_load_s  = 1'b0;
    s2_valid_d = s2_valid_q;
    s2_load_s  = 1'b0;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_ready_s) begin
        s1_valid_d = io.in_valid;
        s1_load_s  = io.in_valid;
      end else begin
        s1_valid_d = s1_valid_q;
      end
      if (s2_adv_s) begin
        s2_valid_d = s1_valid_q;
        s2_load_s  = s1_valid_q;
      end else begin
        s2_valid_d = s2_valid_q;
      end
    end
  end

  // Shifter operand selection: right shifts run on the reversed operand.
  always_comb begin
    x_rev_s    = bit_rev32(s1_data_q);
    main_in_s  = ((s1_op_q == OP_SRL) || (s1_op_q == OP_SRA)) ? x_rev_s : s1_data_q;
    main_amt_s = s1_shamt_q;
    aux_in_s   = ALL_ONES;
    aux_amt_s  = s1_shamt_q;
`ifdef SHIFT_ROTATE_EN
    // ROR by s is ROL by (32-s)&31; the wrap term shifts rev(x) by the complement amount.
    rot_amt_s = (s1_op_q == OP_ROR) ? (5'd0 - s1_shamt_q) : s1_shamt_q;
    if ((s1_op_q == OP_ROL) || (s1_op_q == OP_ROR)) begin
      main_amt_s = rot_amt_s;
      aux_in_s   = x_rev_s;
      aux_amt_s  = 5'd0 - rot_amt_s;
    end else begin
      main_amt_s = s1_shamt_q;
    end
`endif
  end

  barrel_shifter_left #(.WIDTH(XLEN), .AMT_W(SHAMT_W)) u_shl_main (
    .data_i (main_in_s),
    .amt_i  (main_amt_s),
    .data_o (main_out_s)
  );

  barrel_shifter_left #(.WIDTH(XLEN), .AMT_W(SHAMT_W)) u_shl_aux (
    .data_i (aux_in_s),
    .amt_i  (aux_amt_s),
    .data_o (aux_out_s)
  );

  // Result assembly; the aux shifter supplies the sign-fill mask or the rotate wrap term.
  always_comb begin
    res_s     = {XLEN{1'b0}};
    illegal_s = 1'b0;
    case (s1_op_q)
      OP_SLL: res_s = main_out_s;
      OP_SRL: res_s = bit_rev32(main_out_s);
      OP_SRA: res_s = bit_rev32(main_out_s) |
                      (s1_data_q[31] ? ~bit_rev32(aux_out_s) : {XLEN{1'b0}});
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR: res_s = main_out_s |
                      ((rot_amt_s == 5'd0) ? {XLEN{1'b0}} : bit_rev32(aux_out_s));
`endif
      default: begin
        res_s     = {XLEN{1'b0}};
        illegal_s = 1'b1;
      end
    endcase
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= 3'd0;
      s1_data_q    <= {XLEN{1'b0}};
      s1_shamt_q   <= {SHAMT_W{1'b0}};
      s1_tag_q     <= {TAG_W{1'b0}};
      s2_valid_q   <= 1'b0;
      s2_result_q  <= {XLEN{1'b0}};
      s2_tag_q     <= {TAG_W{1'b0}};
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load_s) begin
        s1_op_q    <= io.in_op;
        s1_data_q  <= io.in_data;
        s1_shamt_q <= io.in_shamt;
        s1_tag_q   <= io.in_tag;
      end
      if (s2_load_s) begin
        s2_result_q  <= res_s;
        s2_tag_q     <= s1_tag_q;
        s2_illegal_q <= illegal_s;
      end
    end
  end

  assign io.in_ready    = in_ready_s;
  assign io.out_valid   = s2_valid_q;
  assign io.out_result  = s2_result_q;
  assign io.out_tag     = s2_tag_q;
  assign io.out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed vector table, backpressure/flush/reset sequences and a random scoreboard run
// for shift_exec_pipe; ROL/ROR expectations follow SHIFT_ROTATE_EN.
module tb_shift_exec_pipe;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  localparam int NV    = 22;
  localparam int NRAND = 10000;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_assert;
  int   n_fail;
  vec_t vecs [NV];

  shift_exec_pipe_if #(.TAG_W(5)) bus ();

  shift_exec_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                              input logic [31:0] r, input logic ill);
    vec_t v;
    v.op = op; v.data = d; v.shamt = s; v.exp_res = r; v.exp_ill = ill;
    return v;
  endfunction

  // Reference model built from native shift operators, independent of the reversal scheme.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] x, input logic [4:0] s);
    logic [63:0] xx;
    logic [63:0] t;
    xx = {x, x};
    case (op)
      3'd0: return {1'b0, x << s};
      3'd1: return {1'b0, x >> s};
      3'd2: return {1'b0, 32'($signed(x) >>> s)};
      3'd3: begin
        t = xx << s;
        return ROT ? {1'b0, t[63:32]} : {1'b1, 32'h0};
      end
      3'd4: begin
        t = xx >> s;
        return ROT ? {1'b0, t[31:0]} : {1'b1, 32'h0};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic set_in(input logic v, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [4:0] tag);
    bus.in_valid = v; bus.in_op = op; bus.in_data = d; bus.in_shamt = s; bus.in_tag = tag;
  endtask

  // One op through an empty pipe: not visible after the accept edge, visible after the next.
  task automatic apply(input vec_t v, input logic [4:0] tag, input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_in(1'b1, v.op, v.data, v.shamt, tag);
    #1 chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk({name, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_result"}, 64'(bus.out_result), 64'(v.exp_res));
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    chk({name, "_illegal"}, 64'(bus.out_illegal), 64'(v.exp_ill));
  endtask

  initial begin
    logic [31:0] bp_exp [8];
    logic [31:0] held_res;
    logic [37:0] q [$];
    logic [37:0] e;
    logic [32:0] m;
    int k, nout, cyc, sent, got;

    n_assert = 0;
    n_fail   = 0;

    vecs[0]  = mk(3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    vecs[1]  = mk(3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
    vecs[2]  = mk(3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
    vecs[3]  = mk(3'd2, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0);
    vecs[4]  = mk(3'd0, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234, 1'b0);
    vecs[5]  = mk(3'd1, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234, 1'b0);
    vecs[6]  = mk(3'd2, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234, 1'b0);
    vecs[7]  = mk(3'd3, 32'hA5A5_1234, 5'd0,  ROT ? 32'hA5A5_1234 : 32'h0, !ROT);
    vecs[8]  = mk(3'd4, 32'hA5A5_1234, 5'd0,  ROT ? 32'hA5A5_1234 : 32'h0, !ROT);
    vecs[9]  = mk(3'd3, 32'h8000_0001, 5'd1,  ROT ? 32'h0000_0003 : 32'h0, !ROT);
    vecs[10] = mk(3'd4, 32'h0000_0001, 5'd1,  ROT ? 32'h8000_0000 : 32'h0, !ROT);
    vecs[11] = mk(3'd3, 32'h1234_5678, 5'd8,  ROT ? 32'h3456_7812 : 32'h0, !ROT);
    vecs[12] = mk(3'd4, 32'h1234_5678, 5'd8,  ROT ? 32'h7812_3456 : 32'h0, !ROT);
    vecs[13] = mk(3'd0, 32'h1234_5678, 5'd4,  32'h2345_6780, 1'b0);
    vecs[14] = mk(3'd2, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 1'b0);
    vecs[15] = mk(3'd1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0);
    vecs[16] = mk(3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
    vecs[17] = mk(3'd5, 32'h0000_FFFF, 5'd3,  32'h0000_0000, 1'b1);
    vecs[18] = mk(3'd7, 32'hDEAD_BEEF, 5'd0,  32'h0000_0000, 1'b1);
    vecs[19] = mk(3'd2, 32'hC000_0000, 5'd1,  32'hE000_0000, 1'b0);
    vecs[20] = mk(3'd3, 32'h8000_0000, 5'd31, ROT ? 32'h4000_0000 : 32'h0, !ROT);
    vecs[21] = mk(3'd4, 32'h0000_0003, 5'd31, ROT ? 32'h0000_0006 : 32'h0, !ROT);

    // Reset values
    rst_n = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    set_in(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    end

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], 5'(i), $sformatf("vec%0d", i));
    end

    // Backpressure: 8 ops, out_ready low for the first 5 cycles
    for (int i = 0; i < 8; i++) bp_exp[i] = (32'h100 + 32'(i)) << i;
    @(negedge clk);
    k = 0; nout = 0; cyc = 0; held_res = 32'h0;
    while (nout < 8 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      if (k < 8) set_in(1'b1, 3'd0, 32'h100 + 32'(k), 5'(k), 5'(k));
      else bus.in_valid = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_hold_tag", 64'(bus.out_tag), 64'd0);
        chk("bp_hold_result", 64'(bus.out_result), 64'(bp_exp[0]));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_order_tag", 64'(bus.out_tag), 64'(nout));
        chk("bp_result", 64'(bus.out_result), 64'(bp_exp[nout % 8]));
        nout++;
      end
      if (bus.in_valid && bus.in_ready) k++;
      cyc++;
    end
    chk("bp_all_out", 64'(nout), 64'd8);
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 chk("bp_no_dup", 64'(bus.out_valid), 64'd0);
    end

    // Flush with two ops in flight and a third offered
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_in(1'b1, 3'd1, 32'hF000_0000, 5'd4, 5'd10);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b1, 3'd0, 32'h0000_0001, 5'd1, 5'd11);
    #1 chk("fl_acceptB", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b1, 3'd0, 32'h0000_0002, 5'd1, 5'd12);
    flush = 1'b1;
    #1 chk("fl_pre_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_keep_result", 64'(bus.out_result), 64'h0F00_0000);
    chk("fl_keep_tag", 64'(bus.out_tag), 64'd10);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      #1 chk("fl_none_emerge", 64'(bus.out_valid), 64'd0);
    end

    // Flush in the same cycle an op is accepted drops that op too
    @(negedge clk);
    set_in(1'b1, 3'd0, 32'h0000_0005, 5'd1, 5'd14);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b1, 3'd0, 32'h0000_0006, 5'd1, 5'd15);
    flush = 1'b1;
    #1 chk("fl2_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1 chk("fl2_none_emerge", 64'(bus.out_valid), 64'd0);
    end
    apply(mk(3'd0, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0), 5'd13, "post_flush");

    // Random ops, random out_ready, scoreboard in order
    sent = 0; got = 0; cyc = 0;
    while ((sent < NRAND || q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      if (sent < NRAND && $urandom_range(0, 3) != 0)
        set_in(1'b1, 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 5'(sent));
      else
        bus.in_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rand_extra_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rand_result", 64'(bus.out_result), 64'(e[31:0]));
          chk("rand_tag", 64'(bus.out_tag), 64'(e[36:32]));
          chk("rand_illegal", 64'(bus.out_illegal), 64'(e[37]));
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        m = model(bus.in_op, bus.in_data, bus.in_shamt);
        q.push_back({m[32], bus.in_tag, m[31:0]});
        sent++;
      end
      cyc++;
    end
    chk("rand_count", 64'(got), 64'(NRAND));
    bus.in_valid = 1'b0;

    // Asynchronous reset with both stages full
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_in(1'b1, 3'd0, 32'h0000_0001, 5'd3, 5'd21);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b1, 3'd0, 32'h0000_0001, 5'd4, 5'd22);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("mid_full_in_ready", 64'(bus.in_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_result", 64'(bus.out_result), 64'd0);
    chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("mid_rst_lost", 64'(bus.out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
